// File: rtl/image_scan_ctrl.sv
// Row-scanning LED matrix controller: fetches a ROM row, serialises it, latches it and holds it lit.
// Optional MIRROR_EN: shift rows LSB first (horizontal mirror); default is MSB first.
module image_scan_ctrl #(
    parameter int unsigned ROWS        = 32,
    parameter int unsigned COLS        = 32,
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     imgSel,
    output logic [$clog2(ROWS)-1:0]  addRom,
    input  logic [COLS-1:0]          dataRom0,
    input  logic [COLS-1:0]          dataRom1,
    output logic                     serData,
    output logic                     serClk,
    output logic                     rowLatch,
    output logic [$clog2(ROWS)-1:0]  rowSel,
    output logic                     blank,
    output logic                     frameDone,
    output logic                     busy
);

    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned BIT_W  = $clog2(COLS);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT, S_LATCH, S_HOLD, S_NEXT
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    row_sel_q, row_sel_d;
    logic                img_q, img_d;
    logic [COLS-1:0]     shift_q, shift_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                phase_q, phase_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                latch_q, latch_d;
    logic                blank_q, blank_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            row_sel_q <= '0;
            img_q     <= 1'b0;
            shift_q   <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            hold_q    <= '0;
            latch_q   <= 1'b0;
            blank_q   <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            row_sel_q <= row_sel_d;
            img_q     <= img_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            latch_q   <= latch_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        row_sel_d = row_sel_q;
        img_d     = img_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        phase_d   = 1'b0;
        hold_d    = hold_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    img_d   = imgSel;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                shift_d = img_q ? dataRom1 : dataRom0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // The last bit is not shifted out so serData keeps it through latch and hold.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (bit_q == BIT_W'(COLS - 1)) begin
                    state_d = S_LATCH;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
`ifdef MIRROR_EN
                    shift_d = shift_q >> 1;
`else
                    shift_d = shift_q << 1;
`endif
                end
            end
            S_LATCH: begin
                row_sel_d = row_q;
                hold_d    = '0;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_NEXT;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_NEXT: begin
                if (row_q == ROW_W'(ROWS - 1)) begin
                    row_d = '0;
                    if (enable) begin
                        img_d   = imgSel;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output flops are loaded from the state being entered so they line up with it.
        latch_d = (state_d == S_LATCH);
        blank_d = (state_d != S_HOLD);
        done_d  = (state_d == S_NEXT) && (row_q == ROW_W'(ROWS - 1));
        busy_d  = (state_d != S_IDLE);
    end

`ifdef MIRROR_EN
    assign serData = shift_q[0];
`else
    assign serData = shift_q[COLS-1];
`endif

    assign addRom    = row_q;
    assign serClk    = phase_q;
    assign rowLatch  = latch_q;
    assign rowSel    = row_sel_q;
    assign blank     = blank_q;
    assign frameDone = done_q;
    assign busy      = busy_q;

endmodule
